dmem_responder: RTL and testbench

//   Data-memory responder: the slave end of the processor's data bus.
//   It accepts load/store requests (address = ALUResult, data = WriteData) and answers after a fixed number of wait states.
//   It returns ReadData and an error flag.

---
 rtl/dmem_responder.sv | 100 ++++++++++
 tb/tb_dmem_responder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: word-addressed RAM behind a valid/ready request port,
// answering each load/store with a one-cycle response pulse after LAT wait states.
module dmem_responder #(
  parameter int DEPTH = 64,
  parameter int LAT   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          we_p0;
  logic [31:0]   addr_p0;
  logic [31:0]   wdata_p0;
  logic [31:0]   mem [DEPTH];

  logic          accept;
  logic          access;
  logic          err;
  logic [AW-1:0] widx;

  assign accept    = (state_q == IDLE) && req_valid;
  assign access    = (state_q == WAIT) && (cnt_q == '0);
  assign err       = (addr_p0[1:0] != 2'b00) || ({2'b00, addr_p0[31:2]} >= 32'(DEPTH));
  assign widx      = addr_p0[AW+1:2];
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid) state_d = WAIT;
      WAIT:    if (cnt_q == '0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture: frozen from the accept edge until the access completes
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0    <= req_we;
      addr_p0  <= req_addr;
      wdata_p0 <= req_wdata;
    end
  end

  // A reset forces IDLE, so an aborted store can never reach this write
  always_ff @(posedge clk) begin
    if (access && !err && we_p0) begin
      mem[widx] <= wdata_p0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (req_valid) cnt_q <= CW'(LAT - 1);
        end
        WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            rsp_err   <= err;
            rsp_rdata <= (!err && !we_p0) ? mem[widx] : 32'h0;
          end
        end
        RESP: begin
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
        end
        default: begin
          cnt_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised self-checking bench for dmem_responder: a LAT=2 and a LAT=1 instance
// checked against a transaction-level memory model and the response timing rules.
module tb_dmem_responder;

  localparam int DEPTH = 64;
  localparam int LAT0  = 2;
  localparam int LAT1  = 1;

  logic        clk;
  logic        reset;
  logic        v0, v1;
  logic        we;
  logic [31:0] addr, wdata;
  logic        rdy0, rdy1, rv0, rv1, er0, er1;
  logic [31:0] rd0, rd1;

  int sel;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_rsp = 0;

  logic        ordy, ovld, oerr;
  logic [31:0] ordata;

  logic [31:0] mdl [2][DEPTH];
  bit          wr  [2][DEPTH];

  assign ordy   = (sel != 0) ? rdy1 : rdy0;
  assign ovld   = (sel != 0) ? rv1  : rv0;
  assign oerr   = (sel != 0) ? er1  : er0;
  assign ordata = (sel != 0) ? rd1  : rd0;

  dmem_responder #(.DEPTH(DEPTH), .LAT(LAT0)) u_dut (
    .clk(clk), .reset(reset), .req_valid(v0), .req_ready(rdy0), .req_we(we),
    .req_addr(addr), .req_wdata(wdata), .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(er0)
  );

  dmem_responder #(.DEPTH(DEPTH), .LAT(LAT1)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(v1), .req_ready(rdy1), .req_we(we),
    .req_addr(addr), .req_wdata(wdata), .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(er1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Transaction-level expectation: serialised accesses make memory a plain array
  task automatic model(input bit w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] erd, output bit known, output bit e);
    e     = (a % 4 != 0) || ((a >> 2) >= 32'(DEPTH));
    erd   = 32'h0;
    known = 1'b1;
    if (!e) begin
      if (w) begin
        mdl[sel][a >> 2] = d;
        wr[sel][a >> 2]  = 1'b1;
      end else begin
        erd   = mdl[sel][a >> 2];
        known = wr[sel][a >> 2];
      end
    end
  endtask

  // Present a request at a negedge, return at the negedge after the accept edge
  task automatic accept(input bit w, input logic [31:0] a, input logic [31:0] d,
                        input bit keep, output bit ok);
    we = w; addr = a; wdata = d;
    if (sel != 0) v1 = 1'b1; else v0 = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ordy) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    if (!keep) begin
      v0 = 1'b0;
      v1 = 1'b0;
    end
    we = 1'($urandom); addr = $urandom; wdata = $urandom;
  endtask

  task automatic xact(input bit w, input logic [31:0] a, input logic [31:0] d,
                      input bit keep, input string tag);
    int lat;
    logic [31:0] erd;
    bit known, e, ok;
    lat = (sel != 0) ? LAT1 : LAT0;
    model(w, a, d, erd, known, e);
    accept(w, a, d, keep, ok);
    if (!ok) return;
    for (int k = 1; k <= lat; k++) begin
      chk({tag, ".wait_vld"}, 32'(ovld), 32'd0);
      chk({tag, ".wait_rdy"}, 32'(ordy), 32'd0);
      @(negedge clk);
    end
    chk({tag, ".rsp_vld"}, 32'(ovld), 32'd1);
    chk({tag, ".rsp_rdy"}, 32'(ordy), 32'd0);
    chk({tag, ".rsp_err"}, 32'(oerr), 32'(e));
    if (known) chk({tag, ".rdata"}, ordata, erd);
    last_rsp = cyc;
    @(negedge clk);
    chk({tag, ".idle_vld"}, 32'(ovld), 32'd0);
    chk({tag, ".idle_rdy"}, 32'(ordy), 32'd1);
    chk({tag, ".idle_rdata"}, ordata, 32'd0);
    chk({tag, ".idle_err"}, 32'(oerr), 32'd0);
  endtask

  initial begin
    int rsp_cyc [6];
    bit ok;
    logic [31:0] a;

    sel = 0; reset = 1'b0; v0 = 1'b0; v1 = 1'b0;
    we = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst.ready", 32'(rdy0), 32'd1);
    chk("rst.valid", 32'(rv0), 32'd0);
    chk("rst.rdata", rd0, 32'd0);
    chk("rst.err", 32'(er0), 32'd0);
    chk("rst.ready1", 32'(rdy1), 32'd1);
    reset = 1'b1;
    @(negedge clk);

    // Reset asserted mid-WAIT must take effect without a clock edge
    accept(1'b1, 32'h40, 32'hCAFE0001, 1'b0, ok);
    #2 reset = 1'b0;
    #1;
    chk("async.ready", 32'(rdy0), 32'd1);
    chk("async.valid", 32'(rv0), 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("async.hold_valid", 32'(rv0), 32'd0);
    end
    reset = 1'b1;
    @(negedge clk);
    xact(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, "t1.st");
    xact(1'b0, 32'h10, 32'h0, 1'b0, "t1.ld");

    xact(1'b0, 32'h10, 32'h0, 1'b0, "t2.lat");

    xact(1'b1, 32'h13, 32'h11112222, 1'b0, "t3.mis");
    xact(1'b0, 32'h10, 32'h0, 1'b0, "t3.ld");
    xact(1'b0, 32'h100, 32'h0, 1'b0, "t3.oor");

    // Back-to-back with req_valid held high throughout
    for (int i = 0; i < 3; i++) begin
      xact(1'b1, 32'(4 * i), $urandom, 1'b1, "t4.st");
      rsp_cyc[2*i] = last_rsp;
      xact(1'b0, 32'(4 * i), 32'h0, 1'b1, "t4.ld");
      rsp_cyc[2*i+1] = last_rsp;
    end
    v0 = 1'b0;
    for (int i = 1; i < 6; i++) chk("t4.spacing", 32'(rsp_cyc[i] - rsp_cyc[i-1]), 32'(LAT0 + 2));
    @(negedge clk);

    xact(1'b1, 32'h20, 32'hA5A55A5A, 1'b0, "t5.old");
    accept(1'b1, 32'h20, 32'h12345678, 1'b0, ok);
    #2 reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("t5.rst_vld", 32'(rv0), 32'd0);
    end
    reset = 1'b1;
    repeat (LAT0 + 3) begin
      @(negedge clk);
      chk("t5.no_rsp", 32'(rv0), 32'd0);
    end
    xact(1'b0, 32'h20, 32'h0, 1'b0, "t5.ld");

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0:       a = 32'(($urandom_range(0, DEPTH - 1) << 2) | $urandom_range(1, 3));
        1:       a = 32'(4 * DEPTH) + ($urandom_range(0, 255) << 2);
        default: a = 32'($urandom_range(0, 15) << 2);
      endcase
      xact(1'($urandom), a, $urandom, 1'($urandom), "rnd");
    end
    v0 = 1'b0;
    @(negedge clk);

    sel = 1;
    xact(1'b1, 32'(4 * (DEPTH - 1)), 32'h0BADF00D, 1'b0, "t6.st_hi");
    xact(1'b1, 32'h0, 32'h600DCAFE, 1'b0, "t6.st_lo");
    xact(1'b0, 32'(4 * (DEPTH - 1)), 32'h0, 1'b0, "t6.ld_hi");
    xact(1'b0, 32'h0, 32'h0, 1'b0, "t6.ld_lo");
    xact(1'b0, 32'(4 * DEPTH), 32'h0, 1'b0, "t6.oor");
    for (int i = 0; i < 10; i++) begin
      a = 32'($urandom_range(0, DEPTH - 1) << 2);
      xact(1'($urandom), a, $urandom, 1'($urandom), "t6.rnd");
    end
    v1 = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
